// File: rtl/arm_pipeline_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   INSTR_W       instruction width
//   NOP_INSTR     value presented on out_instr when no entry is valid
//   PC_STEP       sequential PC increment
//   fetch_entry_t one queued fetch: {pc, instr}
package arm_pipeline_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry queue of fetch_entry_t with a synchronous flush.
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   flush           empties the queue at the next edge; overrides push/pop
//   push, wr_data   enqueue wr_data (caller guarantees not full)
//   pop             dequeue head (caller guarantees not empty)
//   head            entry at rd_ptr, combinational view
//   count           number of valid entries, 0..DEPTH
module fetch_fifo
  import arm_pipeline_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  fetch_entry_t       wr_data,
  input  logic               pop,
  output fetch_entry_t       head,
  output logic [CNT_W-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Entry contents need no reset: every read is qualified by count.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      storage[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head = storage[rd_ptr];

endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction-fetch front end. Owns the PC, drives the
// instruction-memory address, buffers {pc, instr} pairs in a small queue and
// hands them to decode over a valid/ready handshake. A redirect flushes the
// queue and reloads the PC.
// Ports:
//   clk, reset                rising-edge clock, asynchronous active-high reset
//   fetch_enable              fetch / PC advance permitted this cycle
//   imem_addr, imem_instr     instruction memory (combinational read)
//   redirect_valid/_pc        taken branch: flush and load target
//   out_valid/_ready          head handshake toward decode
//   out_instr/_pc/_pc_plus_4  head entry, zero when !out_valid
//   perf_fetches/_flushes/_full_cyc  saturating event counters
// Optional feature: define FETCH_QUEUE_PERF_EN to build the performance
// counters; otherwise the perf_* ports are tied to zero.
module fetch_queue_unit
  import arm_pipeline_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_enable,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_pc_plus_4,
  output logic [31:0]        perf_fetches,
  output logic [15:0]        perf_flushes,
  output logic [31:0]        perf_full_cyc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]      pc;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             push;
  logic             pop;
  fetch_entry_t     head;
  fetch_entry_t     wr_data;

  // A full queue never pushes, even if the head pops this cycle; the freed
  // slot is used on the following cycle. Redirect suppresses both sides.
  assign full      = (count == CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = fetch_enable && !full && !redirect_valid;
  assign pop       = out_valid && out_ready && !redirect_valid;

  assign wr_data.pc    = pc;
  assign wr_data.instr = imem_instr;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (redirect_valid),
    .push    (push),
    .wr_data (wr_data),
    .pop     (pop),
    .head    (head),
    .count   (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
    end else if (push) begin
      pc <= pc + PC_STEP;
    end
  end

  assign imem_addr = pc[ADDR_W-1:0];

  assign out_instr     = out_valid ? head.instr : NOP_INSTR;
  assign out_pc        = out_valid ? head.pc : 32'h0;
  assign out_pc_plus_4 = out_valid ? (head.pc + PC_STEP) : 32'h0;

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] fetches_cnt;
  logic [15:0] flushes_cnt;
  logic [31:0] full_cnt;

  // All counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetches_cnt <= '0;
      flushes_cnt <= '0;
      full_cnt    <= '0;
    end else begin
      if (push && (fetches_cnt != '1))           fetches_cnt <= fetches_cnt + 1'b1;
      if (redirect_valid && (flushes_cnt != '1)) flushes_cnt <= flushes_cnt + 1'b1;
      if (fetch_enable && full && (full_cnt != '1)) full_cnt <= full_cnt + 1'b1;
    end
  end

  assign perf_fetches  = fetches_cnt;
  assign perf_flushes  = flushes_cnt;
  assign perf_full_cyc = full_cnt;
`else
  assign perf_fetches  = 32'h0;
  assign perf_flushes  = 16'h0;
  assign perf_full_cyc = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed testbench for fetch_queue_unit. Instruction memory returns
// 32'hE000_0000 | imem_addr, so each expected word below is written by hand.
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_enable;
  logic [7:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus_4;
  logic [31:0] perf_fetches;
  logic [15:0] perf_flushes;
  logic [31:0] perf_full_cyc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign imem_instr = 32'hE000_0000 | {24'h0, imem_addr};

  fetch_queue_unit #(
    .DEPTH    (4),
    .ADDR_W   (8),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_enable   (fetch_enable),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus_4  (out_pc_plus_4),
    .perf_fetches   (perf_fetches),
    .perf_flushes   (perf_flushes),
    .perf_full_cyc  (perf_full_cyc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // Advance one clock; leaves time 1 unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    fetch_enable   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc_exp, input logic [31:0] instr_exp);
    check({tag, ".valid"}, {31'h0, out_valid}, 32'h1);
    check({tag, ".pc"}, out_pc, pc_exp);
    check({tag, ".instr"}, out_instr, instr_exp);
  endtask

  initial begin
    // 1: reset release, streaming with out_ready=1
    do_reset();
    check("t1.rst_valid", {31'h0, out_valid}, 32'h0);
    check("t1.rst_addr", {24'h0, imem_addr}, 32'h0);
    check("t1.rst_instr", out_instr, 32'h0);
    check("t1.rst_pc4", out_pc_plus_4, 32'h0);
    fetch_enable = 1'b1;
    out_ready    = 1'b1;
    step();
    check_head("t1.A", 32'h0, 32'hE000_0000);
    check("t1.A_pc4", out_pc_plus_4, 32'h4);
    step();
    check_head("t1.B", 32'h4, 32'hE000_0004);
    step();
    check_head("t1.C", 32'h8, 32'hE000_0008);

    // 2: stall for 6 cycles, queue fills, then drain in order
    do_reset();
    fetch_enable = 1'b1;
    out_ready    = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("t2.addr_held", {24'h0, imem_addr}, 32'h10);
    check_head("t2.h0", 32'h0, 32'hE000_0000);
`ifdef FETCH_QUEUE_PERF_EN
    check("t2.perf_full", perf_full_cyc, 32'd2);
    check("t2.perf_fetch", perf_fetches, 32'd4);
`endif
    out_ready = 1'b1;
    step();
    check_head("t2.h1", 32'h4, 32'hE000_0004);
    check("t2.addr_after", {24'h0, imem_addr}, 32'h10);
    step();
    check_head("t2.h2", 32'h8, 32'hE000_0008);
    step();
    check_head("t2.h3", 32'hC, 32'hE000_000C);
    step();
    check_head("t2.h4", 32'h10, 32'hE000_0010);

    // 3: redirect while 3 entries are queued
    do_reset();
    fetch_enable = 1'b1;
    out_ready    = 1'b0;
    for (int i = 0; i < 3; i++) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    check("t3.flush_valid", {31'h0, out_valid}, 32'h0);
    check("t3.flush_instr", out_instr, 32'h0);
    check("t3.addr", {24'h0, imem_addr}, 32'h40);
    step();
    check_head("t3.target", 32'h40, 32'hE000_0040);
    check("t3.pc4", out_pc_plus_4, 32'h44);

    // 4: redirect with full queue and out_ready=1
    do_reset();
    fetch_enable = 1'b1;
    out_ready    = 1'b0;
    for (int i = 0; i < 4; i++) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    out_ready      = 1'b1;
    step();
    redirect_valid = 1'b0;
    check("t4.empty", {31'h0, out_valid}, 32'h0);
    check("t4.addr", {24'h0, imem_addr}, 32'h80);
`ifdef FETCH_QUEUE_PERF_EN
    check("t4.perf_flush", {16'h0, perf_flushes}, 32'd1);
`endif
    step();
    check_head("t4.target", 32'h80, 32'hE000_0080);

    // 5: async reset between edges
    do_reset();
    fetch_enable = 1'b1;
    out_ready    = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("t5.pre_addr", {24'h0, imem_addr}, 32'hC);
    #2;
    reset = 1'b1;
    #1;
    check("t5.async_valid", {31'h0, out_valid}, 32'h0);
    check("t5.async_addr", {24'h0, imem_addr}, 32'h0);
    reset = 1'b0;
    step();
    check_head("t5.restart", 32'h0, 32'hE000_0000);

    // 6: address wrap at 0x100
    do_reset();
    fetch_enable   = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFC;
    step();
    redirect_valid = 1'b0;
    check("t6.addr_fc", {24'h0, imem_addr}, 32'hFC);
    step();
    check("t6.addr_wrap", {24'h0, imem_addr}, 32'h00);
    check_head("t6.h_fc", 32'hFC, 32'hE000_00FC);
    step();
    out_ready = 1'b1;
    step();
    check_head("t6.h_100", 32'h100, 32'hE000_0000);
    check("t6.pc4", out_pc_plus_4, 32'h104);
    check("t6.addr_next", {24'h0, imem_addr}, 32'h08);
`ifndef FETCH_QUEUE_PERF_EN
    check("t6.perf_fetch0", perf_fetches, 32'h0);
    check("t6.perf_flush0", {16'h0, perf_flushes}, 32'h0);
    check("t6.perf_full0", perf_full_cyc, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
